// File: rtl/rvc_asap_pkg.sv
// Shared constants, decode enums and helpers for the rvc_asap core.
// Optional feature macro: RVC_EBREAK_HALT_EN (EBREAK halts the core).
package rvc_asap_pkg;

  localparam logic [31:0] I_MEM_MSB    = 32'h0000_0FFF;
  localparam logic [31:0] D_MEM_MSB    = 32'h0000_1FFF;
  localparam logic [31:0] D_MEM_OFFSET = 32'h0000_1000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_t;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_t;

  function automatic logic in_imem(
    input logic [31:0] a
  );
    return a <= I_MEM_MSB;
  endfunction

  function automatic logic in_dmem(
    input logic [31:0] a
  );
    return (a >= D_MEM_OFFSET) &&
           (a <= D_MEM_MSB);
  endfunction

  function automatic logic [31:0] imm_gen(
    input logic [31:0] ins,
    input imm_t        t
  );
    logic [31:0] r;
    case (t)
      IMM_S: r = {{20{ins[31]}},
                  ins[31:25], ins[11:7]};
      IMM_B: r = {{19{ins[31]}}, ins[31],
                  ins[7], ins[30:25],
                  ins[11:8], 1'b0};
      IMM_U: r = {ins[31:12], 12'b0};
      IMM_J: r = {{11{ins[31]}}, ins[31],
                  ins[19:12], ins[20],
                  ins[30:21], 1'b0};
      default: r = {{20{ins[31]}},
                    ins[31:20]};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] alu(
    input alu_op_t     op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    case (op)
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'b0,
                     $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned(
                  $signed(a) >>> b[4:0]);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_PASS_B: r = b;
      default:  r = a + b;
    endcase
    return r;
  endfunction

  function automatic alu_op_t alu_sel(
    input logic [2:0] f3,
    input logic       alt,
    input logic       reg_op
  );
    alu_op_t r;
    case (f3)
      3'd0: r = (reg_op && alt) ? ALU_SUB
                                : ALU_ADD;
      3'd1: r = ALU_SLL;
      3'd2: r = ALU_SLT;
      3'd3: r = ALU_SLTU;
      3'd4: r = ALU_XOR;
      3'd5: r = alt ? ALU_SRA : ALU_SRL;
      3'd6: r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rvc_asap.sv
// Single-cycle RV32I core: decode, register file, ALU, next-PC.
// RVC_EBREAK_HALT_EN makes EBREAK freeze the core until reset.
module rvc_asap (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instruction,
  input  logic [31:0] d_rdata,
  output logic [31:0] pc,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic [1:0]  d_size,
  output logic        d_we
);
  import rvc_asap_pkg::*;

  logic [31:0] regs [31:1];

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] ld_val;
  logic [31:0] wd;
  logic [31:0] pc4;
  logic [31:0] next_pc;
  imm_t        imm_sel;
  alu_op_t     alu_op;
  wb_t         wb_sel;
  logic        use_pc;
  logic        use_imm;
  logic        rf_we;
  logic        is_store;
  logic        is_br;
  logic        is_jal;
  logic        is_jalr;
  logic        taken;
  logic        halt;

  assign opcode = Instruction[6:0];
  assign rd     = Instruction[11:7];
  assign f3     = Instruction[14:12];
  assign rs1    = Instruction[19:15];
  assign rs2    = Instruction[24:20];

  assign rs1_val =
    (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val =
    (rs2 == 5'd0) ? '0 : regs[rs2];

`ifdef RVC_EBREAK_HALT_EN
  assign halt = (Instruction == EBREAK);
`else
  assign halt = 1'b0;
`endif

  // Decode; anything unrecognised falls through as a NOP.
  always_comb begin
    imm_sel  = IMM_I;
    alu_op   = ALU_ADD;
    wb_sel   = WB_ALU;
    use_pc   = 1'b0;
    use_imm  = 1'b0;
    rf_we    = 1'b0;
    is_store = 1'b0;
    is_br    = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm_sel = IMM_U;
        alu_op  = ALU_PASS_B;
        use_imm = 1'b1;
        rf_we   = 1'b1;
      end
      OP_AUIPC: begin
        imm_sel = IMM_U;
        use_pc  = 1'b1;
        use_imm = 1'b1;
        rf_we   = 1'b1;
      end
      OP_JAL: begin
        imm_sel = IMM_J;
        wb_sel  = WB_PC4;
        rf_we   = 1'b1;
        is_jal  = 1'b1;
      end
      OP_JALR: begin
        use_imm = 1'b1;
        wb_sel  = WB_PC4;
        rf_we   = (f3 == 3'd0);
        is_jalr = (f3 == 3'd0);
      end
      OP_BRANCH: begin
        imm_sel = IMM_B;
        is_br   = 1'b1;
      end
      OP_LOAD: begin
        use_imm = 1'b1;
        wb_sel  = WB_MEM;
        rf_we   = (f3 != 3'd3) &&
                  (f3[2:1] != 2'b11);
      end
      OP_STORE: begin
        imm_sel  = IMM_S;
        use_imm  = 1'b1;
        is_store = (f3[2] == 1'b0) &&
                   (f3[1:0] != 2'b11);
      end
      OP_IMM: begin
        alu_op  = alu_sel(f3,
                    Instruction[30], 1'b0);
        use_imm = 1'b1;
        rf_we   = 1'b1;
      end
      OP_OP: begin
        alu_op = alu_sel(f3,
                   Instruction[30], 1'b1);
        rf_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm     = imm_gen(Instruction,
                           imm_sel);
  assign op_a    = use_pc ? pc : rs1_val;
  assign op_b    = use_imm ? imm : rs2_val;
  assign alu_res = alu(alu_op, op_a, op_b);
  assign pc4     = pc + 32'd4;

  // Branch condition from funct3.
  always_comb begin
    case (f3)
      3'd0: taken = rs1_val == rs2_val;
      3'd1: taken = rs1_val != rs2_val;
      3'd4: taken = $signed(rs1_val) <
                    $signed(rs2_val);
      3'd5: taken = $signed(rs1_val) >=
                    $signed(rs2_val);
      3'd6: taken = rs1_val < rs2_val;
      3'd7: taken = rs1_val >= rs2_val;
      default: taken = 1'b0;
    endcase
  end

  // Load extension and write-back select.
  always_comb begin
    case (f3)
      3'd0: ld_val = {{24{d_rdata[7]}},
                      d_rdata[7:0]};
      3'd1: ld_val = {{16{d_rdata[15]}},
                      d_rdata[15:0]};
      3'd4: ld_val = {24'b0, d_rdata[7:0]};
      3'd5: ld_val = {16'b0,
                      d_rdata[15:0]};
      default: ld_val = d_rdata;
    endcase
    case (wb_sel)
      WB_MEM:  wd = ld_val;
      WB_PC4:  wd = pc4;
      default: wd = alu_res;
    endcase
  end

  // Next-PC selection; a halt holds the current PC.
  always_comb begin
    unique case (1'b1)
      halt:    next_pc = pc;
      is_jal:  next_pc = pc + imm;
      is_jalr: next_pc = alu_res &
                         ~32'd1;
      (is_br && taken):
               next_pc = pc + imm;
      default: next_pc = pc4;
    endcase
  end

  assign d_addr  = alu_res;
  assign d_wdata = rs2_val;
  assign d_size  = f3[1:0];
  assign d_we    = is_store && !halt;

  // Program counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else        pc <= next_pc;
  end

  // Register file write port; x0 is not stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++)
        regs[i] <= '0;
    end else if (rf_we && !halt &&
                 rd != 5'd0) begin
      regs[rd] <= wd;
    end
  end

endmodule

// File: rtl/rvc_mem_wrap.sv
// Instruction and data memories with byte-lane fetch, load and store.
// Out-of-window bytes read as zero and are never written.
module rvc_mem_wrap (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_we,
  output logic [31:0] d_rdata
);
  import rvc_asap_pkg::*;

  logic [7:0] IMem [I_MEM_MSB:0];
  logic [7:0] DMem [D_MEM_MSB:I_MEM_MSB+1];

  logic [31:0] f_a [4];
  logic [31:0] d_a [4];
  logic [3:0]  size_mask;
  logic [3:0]  lane_en;

  // Per-byte address lanes; misaligned accesses just walk bytes.
  always_comb begin
    instr   = '0;
    d_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      f_a[i] = pc + 32'(i);
      d_a[i] = d_addr + 32'(i);
      if (in_imem(f_a[i]))
        instr[8*i +: 8] = IMem[f_a[i][11:0]];
      if (in_dmem(d_a[i]))
        d_rdata[8*i +: 8] =
          DMem[d_a[i][12:0]];
    end
  end

  // Select which store lanes land in the data window.
  always_comb begin
    case (d_size)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++)
      lane_en[i] = d_we && rst_n &&
                   size_mask[i] &&
                   in_dmem(d_a[i]);
  end

  // Byte writes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (lane_en[i])
        DMem[d_a[i][12:0]] <=
          d_wdata[8*i +: 8];
  end

endmodule

// File: rtl/rvc_top.sv
// Top level: rvc_asap core plus rvc_mem_wrap memories.
// Optional feature macro: RVC_EBREAK_HALT_EN.
module rvc_top (
  input logic Clock,
  input logic Rst
);
  import rvc_asap_pkg::*;

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic [1:0]  d_size;
  logic        d_we;

  rvc_asap rvc_asap (
    .clk         (Clock),
    .rst_n       (Rst),
    .Instruction (instr),
    .d_rdata     (d_rdata),
    .pc          (pc),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_size      (d_size),
    .d_we        (d_we)
  );

  rvc_mem_wrap rvc_mem_wrap (
    .clk     (Clock),
    .rst_n   (Rst),
    .pc      (pc),
    .instr   (instr),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_size  (d_size),
    .d_we    (d_we),
    .d_rdata (d_rdata)
  );

endmodule

// File: tb/tb_rvc_top.sv
// Directed bench for rvc_top: ALU, memory, control, boundaries,
// mid-run async reset, and EBREAK handling under RVC_EBREAK_HALT_EN.
module tb_rvc_top;

  logic Clock = 1'b0;
  logic Rst   = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [7:0] golden [32'h1000:32'h1FFF];
  logic [31:0] w0;

  always #5 Clock = ~Clock;

  rvc_top dut (
    .Clock (Clock),
    .Rst   (Rst)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  function automatic logic [31:0] xr(
    input int i
  );
    return dut.rvc_asap.regs[i];
  endfunction

  function automatic logic [31:0] dw(
    input int a
  );
    return {dut.rvc_mem_wrap.DMem[a+3],
            dut.rvc_mem_wrap.DMem[a+2],
            dut.rvc_mem_wrap.DMem[a+1],
            dut.rvc_mem_wrap.DMem[a]};
  endfunction

  task automatic put(
    input int          a,
    input logic [31:0] w
  );
    for (int k = 0; k < 4; k++)
      dut.rvc_mem_wrap.IMem[a+k] = w[8*k +: 8];
    if (a == 0) w0 = w;
  endtask

  task automatic clear_all();
    for (int a = 0; a < 32'h1000; a++)
      dut.rvc_mem_wrap.IMem[a] = 8'h00;
    for (int a = 32'h1000; a < 32'h2000; a++) begin
      dut.rvc_mem_wrap.DMem[a] = 8'h00;
      golden[a] = 8'h00;
    end
  endtask

  task automatic hold_reset();
    @(negedge Clock);
    Rst = 1'b0;
    clear_all();
  endtask

  task automatic release_reset(
    input string tag
  );
    logic [31:0] any;
    #40;
    any = '0;
    for (int i = 1; i < 32; i++) any |= xr(i);
    check({tag, "_rst_regs"}, any, 32'h0);
    check({tag, "_rst_pc"},
          dut.rvc_asap.pc, 32'h0);
    @(negedge Clock);
    Rst = 1'b1;
    #1;
    check({tag, "_first_instr"},
          dut.rvc_asap.Instruction, w0);
  endtask

  task automatic run_to(
    input string       tag,
    input logic [31:0] tgt
  );
    int n;
    n = 0;
    while (dut.rvc_asap.pc !== tgt && n < 300) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_reach_pc"},
          dut.rvc_asap.pc, tgt);
  endtask

  task automatic dmem_cmp(
    input string tag
  );
    int bad;
    bad = 0;
    for (int a = 32'h1000; a < 32'h2000; a++)
      if (dut.rvc_mem_wrap.DMem[a] !== golden[a])
        bad++;
    check({tag, "_dmem_golden"}, 32'(bad), 32'h0);
  endtask

  initial begin
    w0 = '0;

    // Program 1: ALU, control flow, memory, EBREAK.
    hold_reset();
    put(32'h00, 32'h00500093);
    put(32'h04, 32'hFFD00113);
    put(32'h08, 32'h002081B3);
    put(32'h0C, 32'h00113233);
    put(32'h10, 32'h008000EF);
    put(32'h14, 32'h00100493);
    put(32'h18, 32'h00000463);
    put(32'h1C, 32'h00100513);
    put(32'h20, 32'h000012B7);
    put(32'h24, 32'h1AB00313);
    put(32'h28, 32'h0062A023);
    put(32'h2C, 32'h00128383);
    put(32'h30, 32'h0002C403);
    put(32'h34, 32'h00100073);
    put(32'h38, 32'h00700593);
    put(32'h3C, 32'h0000006F);
    golden[32'h1000] = 8'hAB;
    golden[32'h1001] = 8'h01;
    release_reset("p1");
`ifdef RVC_EBREAK_HALT_EN
    run_to("p1", 32'h34);
    repeat (5) @(negedge Clock);
    check("p1_halt_pc", dut.rvc_asap.pc, 32'h34);
    check("p1_halt_instr",
          dut.rvc_asap.Instruction, 32'h00100073);
    check("p1_x11", xr(11), 32'h0);
`else
    run_to("p1", 32'h3C);
    repeat (3) @(negedge Clock);
    check("p1_spin_pc", dut.rvc_asap.pc, 32'h3C);
    check("p1_x11", xr(11), 32'h7);
`endif
    check("p1_x1_jal", xr(1), 32'h14);
    check("p1_x2", xr(2), 32'hFFFFFFFD);
    check("p1_x3_add", xr(3), 32'h2);
    check("p1_x4_sltu", xr(4), 32'h0);
    check("p1_x5_lui", xr(5), 32'h1000);
    check("p1_x6", xr(6), 32'h1AB);
    check("p1_x7_lb", xr(7), 32'h1);
    check("p1_x8_lbu", xr(8), 32'hAB);
    check("p1_x9_skip", xr(9), 32'h0);
    check("p1_x10_skip", xr(10), 32'h0);
    check("p1_sw_word", dw(32'h1000), 32'h000001AB);
    dmem_cmp("p1");

    // Program 3: window edges, misalignment, shifts, x0.
    hold_reset();
    put(32'h00, 32'h000022B7);
    put(32'h04, 32'hFFF00313);
    put(32'h08, 32'hFE62AF23);
    put(32'h0C, 32'hFFE2A383);
    put(32'h10, 32'hFFE29403);
    put(32'h14, 32'hFFF2D483);
    put(32'h18, 32'h00032533);
    put(32'h1C, 32'h01C35593);
    put(32'h20, 32'h40700633);
    put(32'h24, 32'h40865693);
    put(32'h28, 32'h00500013);
    put(32'h2C, 32'h00900713);
    put(32'h30, 32'h0FF0000F);
    put(32'h34, 32'h0000006F);
    golden[32'h1FFE] = 8'hFF;
    golden[32'h1FFF] = 8'hFF;
    release_reset("p3");
    run_to("p3", 32'h34);
    check("p3_lw_edge", xr(7), 32'h0000FFFF);
    check("p3_lh_edge", xr(8), 32'hFFFFFFFF);
    check("p3_lhu_edge", xr(9), 32'h000000FF);
    check("p3_slt", xr(10), 32'h1);
    check("p3_srli", xr(11), 32'hF);
    check("p3_sub", xr(12), 32'hFFFF0001);
    check("p3_srai", xr(13), 32'hFFFFFF00);
    check("p3_x0_read", xr(14), 32'h9);
    dmem_cmp("p3");

    // Program 2: store loop, reset asserted between edges.
    hold_reset();
    put(32'h00, 32'h000012B7);
    put(32'h04, 32'h00100313);
    put(32'h08, 32'h00628023);
    put(32'h0C, 32'h00128293);
    put(32'h10, 32'h00130313);
    put(32'h14, 32'hFF5FF06F);
    release_reset("p2");
    repeat (22) @(negedge Clock);
    check("p2_pre_pc", dut.rvc_asap.pc, 32'h08);
    #2;
    Rst = 1'b0;
    #1;
    check("p2_async_pc", dut.rvc_asap.pc, 32'h0);
    check("p2_async_x5", xr(5), 32'h0);
    repeat (4) @(negedge Clock);
    check("p2_loop_bytes", dw(32'h1000), 32'h04030201);
    check("p2_no_more", dw(32'h1004), 32'h00000005);
    check("p2_hold_pc", dut.rvc_asap.pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rvc_top.md
RVC_TOP -- requirements
Module: rvc_top

Interface
REQ-001 Parameters: none; all sizes SHALL come from package constants (REQ-030).
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 No other ports; observability SHALL be via hierarchical paths rvc_top.rvc_asap.Instruction (32-bit), rvc_top.rvc_mem_wrap.IMem and rvc_top.rvc_mem_wrap.DMem.
REQ-005 IMem SHALL be declared logic [7:0] IMem [I_MEM_MSB:0]; DMem SHALL be declared logic [7:0] DMem [D_MEM_MSB:I_MEM_MSB+1], so a testbench can force/backdoor-load them.

Function
REQ-006 Single-cycle RV32I core: one instruction fetched, executed and retired per Clock cycle; CPI = 1.
REQ-007 Address map: IMem 0x0000-0x0FFF (4 KB), DMem 0x1000-0x1FFF (4 KB), byte-addressed, little-endian.
REQ-008 Fetch: Instruction = {IMem[PC+3],IMem[PC+2],IMem[PC+1],IMem[PC]}, combinational from PC.
REQ-009 Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP ALU ops.
REQ-010 FENCE, ECALL, CSR and undecoded opcodes SHALL execute as NOP (PC+4, no state change).
REQ-011 Shift amount = low 5 bits of operand; SLT/SLTI signed, SLTU/SLTIU unsigned; arithmetic wraps modulo 2^32.
REQ-012 Next PC: PC+4 default; JAL PC+immJ; JALR (rs1+immI)&~1; taken branch PC+immB; rd gets PC+4 for JAL/JALR.
REQ-013 x0 reads 0 always; writes to x0 discarded.
REQ-014 Register file: 31x32-bit, two combinational read ports, one write port updated at rising edge.
REQ-015 Loads: combinational DMem read; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-016 Stores: DMem bytes written at rising edge; SB 1 byte, SH 2, SW 4.
REQ-017 Misaligned loads/stores SHALL be performed byte-wise without trap.
REQ-018 Data accesses to any byte outside 0x1000-0x1FFF: read 0, write ignored; IMem not writable by the core.
REQ-019 PC wraps modulo 2^32; fetch outside IMem returns 0x00000000 (NOP-free illegal -> REQ-010 NOP).

Reset
REQ-020 While Rst=0: PC=0x00000000, x1-x31=0, no register or DMem write occurs.
REQ-021 Reset assertion SHALL take effect immediately, independent of Clock, including mid-program; first fetch after release is from 0x0000.
REQ-022 IMem and DMem contents SHALL NOT be cleared by reset (preserve backdoor load).

Configuration
REQ-023 Macro RVC_EBREAK_HALT_EN: when defined, EBREAK (0x00100073) halts the core: PC holds, no register/memory writes, Instruction stays 0x00100073 until reset.
REQ-024 Without RVC_EBREAK_HALT_EN, EBREAK executes as NOP (PC+4).

Structure
REQ-030 Package rvc_asap_pkg SHALL hold I_MEM_MSB=0x0FFF, D_MEM_MSB=0x1FFF, D_MEM_OFFSET=0x1000, opcode localparams, and typedefs for ALU op and immediate-type enums.
REQ-031 Core logic instance named rvc_asap; one sub-module rvc_mem_wrap holds IMem/DMem and the byte-lane read/write logic.

Verification
REQ-040 Reset: Rst=0 for 40 ns, release -> first Instruction equals IMem bytes 0-3; x1-x31 read 0.
REQ-041 ALU: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sltu x4,x2,x1 -> x3=2, x4=0.
REQ-042 Memory: lui x5,0x1; addi x6,x0,0x1AB; sw x6,0(x5); lb x7,1(x5); lbu x8,0(x5) -> DMem[0x1000..0x1003]=AB 01 00 00, x7=1, x8=0xAB.
REQ-043 Control: beq x0,x0,+8 skips next instruction; jal x1,+8 at PC 0x10 -> x1=0x14, PC=0x18.
REQ-044 EBREAK with RVC_EBREAK_HALT_EN: program ending 0x00100073 -> Instruction stays 0x00100073; DMem snapshot 0x1000-0x1FFF matches golden.
REQ-045 Async reset mid-run: assert Rst=0 between edges during a store loop -> PC=0 immediately, no further DMem writes.
